serial_and_rx: RTL and testbench
================================

SERIAL_AND_RX -- requirements
Module: serial_and_rx

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL provide port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL provide port clear  input  1  synchronous abort of any operand in progress.
REQ-005 The block SHALL provide port in_valid  input  1  a_bit/b_bit carry a valid beat this cycle.
REQ-006 The block SHALL provide port in_ready  output  1  block accepts a beat this cycle.
REQ-007 The block SHALL provide port a_bit  input  1  serial operand A, LSB first.
REQ-008 The block SHALL provide port b_bit  input  1  serial operand B, LSB first.
REQ-009 The block SHALL provide port out_valid  output  1  f holds a complete result.
REQ-010 The block SHALL provide port out_ready  input  1  consumer accepts f this cycle.
REQ-011 The block SHALL provide port f  output  WIDTH  parallel result A & B.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, HOLD.
REQ-013 A beat SHALL be accepted only on a cycle where in_valid and in_ready are both high; gaps in in_valid SHALL be tolerated without loss or duplication.
REQ-014 in_ready SHALL be high in IDLE and SHIFT, low in HOLD; in_ready SHALL be a registered or state-decoded signal with no combinational path from out_ready.
REQ-015 The k-th accepted beat (k = 0..WIDTH-1) SHALL set result bit k to a_bit & b_bit.
REQ-016 IDLE -> SHIFT on the first accepted beat; SHIFT -> HOLD on the WIDTH-th accepted beat; HOLD -> IDLE when out_valid and out_ready are both high.
REQ-017 out_valid SHALL rise on the cycle after the WIDTH-th beat is accepted (latency 1 cycle), and f SHALL be valid on that same cycle.
REQ-018 In HOLD, f and out_valid SHALL remain stable until the handshake completes, regardless of in_valid.
REQ-019 After the out handshake, out_valid SHALL fall the next cycle, in_ready SHALL be high that same cycle, and f SHALL retain its last value.
REQ-020 Sustained throughput with in_valid and out_ready held high SHALL be one result per WIDTH+1 cycles.
REQ-021 The beat counter SHALL count 0..WIDTH-1 and wrap to 0 on entry to HOLD; it SHALL never exceed WIDTH-1.
REQ-022 clear SHALL take priority over every other event: next state IDLE, counter 0, partial bits discarded, out_valid 0, f forced to 0.
REQ-023 A beat presented on the same cycle as clear SHALL be discarded.

Reset
REQ-024 On rst_n low, the block SHALL immediately force state IDLE, counter 0, f = 0, out_valid = 0, in_ready = 0.
REQ-025 in_ready SHALL become 1 on the first clock edge after rst_n deasserts; reset mid-operation SHALL discard all partial data.

Structure
REQ-026 A shared package serial_and_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-027 The serial-in/parallel-out register SHALL be a sub-module sipo_shift (WIDTH, enable, serial in, parallel out, synchronous clear); FSM and counter SHALL live in serial_and_rx.

Verification
REQ-028 WIDTH=8, A=0xF0, B=0x3C over 8 consecutive beats, out_ready=1 -> out_valid high exactly 1 cycle after beat 8, f=0x30.
REQ-029 A=0xFF, B=0xA5 with in_valid low for 2 cycles between every beat -> f=0xA5, exactly 8 beats consumed.
REQ-030 Result ready, out_ready held low 5 cycles while in_valid=1 -> in_ready=0, f and out_valid stable throughout; handshake on cycle 6 -> IDLE next cycle.
REQ-031 clear asserted after 3 beats, then A=0xFF, B=0xAA -> f=0xAA, with no bits from the aborted operand present.
REQ-032 rst_n pulsed low asynchronously mid-SHIFT (between clock edges) -> outputs zero immediately; next full operand A=0x0F, B=0xFF gives f=0x0F.
REQ-033 Back-to-back operands, in_valid and out_ready held high -> out_valid pulses every 9 cycles with the correct results.

Source files
------------

// File: rtl/serial_and_pkg.sv
// Shared types and defaults for the serial AND receiver.
// Holds the receive FSM state type and the default operand width.
package serial_and_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out register, LSB first: each enabled beat enters at the MSB.
// After exactly WIDTH beats, the first beat has reached bit 0.
module sipo_shift
    import serial_and_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_and_rx.sv
// Receives two LSB-first serial operands and presents their bitwise AND in parallel.
// f comes straight from the SIPO register, which shifts only on accepted beats.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for the first beat of an operand
// ST_SHIFT | collecting beats 1..WIDTH-1
// ST_HOLD  | result on f, out_valid high, waiting for out_ready
module serial_and_rx
    import serial_and_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_beat;

    // A beat arriving together with clear is dropped.
    assign accept    = in_valid & in_ready & ~clear;
    assign last_beat = accept & (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_beat) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_valid && out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    // in_ready/out_valid are decoded from the next state and registered,
    // so neither handshake output depends combinationally on an input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_HOLD);
            out_valid <= (state_nxt == ST_HOLD);
            if (clear) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (accept),
        .din    (a_bit & b_bit),
        .q      (f)
    );

endmodule

// File: tb/tb_serial_and_rx.sv
// Directed bench for serial_and_rx: vector table plus hand-written corner sequences.
module tb_serial_and_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic       a_bit;
    logic       b_bit;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] f;

    int n_total = 0;
    int n_pass  = 0;
    int n_beats = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         gap;
        logic       ordy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    serial_and_rx #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready && !clear) n_beats++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Drives 8 beats starting at a negedge; returns at the negedge after the last beat.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) begin
            wait_ready();
            if (i == 7) check("pre_valid", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1;
            a_bit    = a[i];
            b_bit    = b[i];
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 7) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic handshake(input logic [7:0] exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_valid_fall", {31'd0, out_valid}, 32'd0);
        check("hs_ready_rise", {31'd0, in_ready}, 32'd1);
        check("hs_f_retain", {24'd0, f}, {24'd0, exp});
    endtask

    initial begin
        int         b0;
        logic [7:0] ops_a [3];
        logic [7:0] ops_b [3];
        logic [7:0] ops_e [3];

        vecs[0] = '{a: 8'hF0, b: 8'h3C, gap: 0, ordy: 1'b1, exp: 8'h30};
        vecs[1] = '{a: 8'hFF, b: 8'hA5, gap: 2, ordy: 1'b1, exp: 8'hA5};
        vecs[2] = '{a: 8'h00, b: 8'hFF, gap: 1, ordy: 1'b0, exp: 8'h00};
        vecs[3] = '{a: 8'h5A, b: 8'h0F, gap: 0, ordy: 1'b0, exp: 8'h0A};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, gap: 3, ordy: 1'b1, exp: 8'hFF};
        ops_a = '{8'hC3, 8'h12, 8'hFF};
        ops_b = '{8'h99, 8'h36, 8'h7E};
        ops_e = '{8'h81, 8'h12, 8'h7E};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        a_bit = 1'b0; b_bit = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_f", {24'd0, f}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven operands
        for (int v = 0; v < 5; v++) begin
            out_ready = vecs[v].ordy;
            b0 = n_beats;
            send_op(vecs[v].a, vecs[v].b, vecs[v].gap);
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("vec_f", {24'd0, f}, {24'd0, vecs[v].exp});
            check("vec_beats", n_beats - b0, 32'd8);
            if (vecs[v].ordy) begin
                @(negedge clk);
                out_ready = 1'b0;
                check("pulse_fall", {31'd0, out_valid}, 32'd0);
                check("pulse_ready", {31'd0, in_ready}, 32'd1);
                check("pulse_f", {24'd0, f}, {24'd0, vecs[v].exp});
            end else begin
                check("hold_ready", {31'd0, in_ready}, 32'd0);
                handshake(vecs[v].exp);
            end
        end

        // Back-pressure: result held while in_valid stays high
        b0 = n_beats;
        send_op(8'h3C, 8'hFF, 0);
        in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_f", {24'd0, f}, 32'h3C);
        end
        in_valid = 1'b0;
        handshake(8'h3C);
        check("bp_beats", n_beats - b0, 32'd8);

        // Clear after 3 beats, with a beat presented alongside clear
        b0 = n_beats;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_f", {24'd0, f}, 32'd0);
        check("clr_ready", {31'd0, in_ready}, 32'd1);
        check("clr_beats", n_beats - b0, 32'd3);
        send_op(8'hFF, 8'hAA, 0);
        check("clr_res_valid", {31'd0, out_valid}, 32'd1);
        check("clr_res_f", {24'd0, f}, 32'hAA);
        handshake(8'hAA);

        // Asynchronous reset mid-operand
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_f", {24'd0, f}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", {31'd0, in_ready}, 32'd1);
        b0 = n_beats;
        send_op(8'h0F, 8'hFF, 0);
        check("arst_res_f", {24'd0, f}, 32'h0F);
        check("arst_beats", n_beats - b0, 32'd8);
        handshake(8'h0F);

        // Back-to-back with in_valid and out_ready held high
        b0 = n_beats;
        out_ready = 1'b1;
        for (int op = 0; op < 3; op++) begin
            for (int c = 0; c < 9; c++) begin
                in_valid = 1'b1;
                a_bit = (c < 8) ? ops_a[op][c] : 1'b1;
                b_bit = (c < 8) ? ops_b[op][c] : 1'b1;
                check("b2b_valid", {31'd0, out_valid}, {31'd0, (c == 8)});
                if (c == 8) check("b2b_f", {24'd0, f}, {24'd0, ops_e[op]});
                @(negedge clk);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_end_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_end_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_beats", n_beats - b0, 32'd24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
